// File: rtl/usbh_crc_pkg.sv
// Shared types and constants for the USB host CRC engine.
// Used by usbh_crc_step and usbh_crc_engine (optional feature macro: USBH_CRC_MATCH_EN).
package usbh_crc_pkg;

   // FSM states of the serial CRC engine
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } crc_state_e;

   // Generator polynomials (top term implied) and good-packet residues
   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_RES  = 16'h800D;
   localparam logic [4:0]  CRC5_POLY  = 5'h05;
   localparam logic [4:0]  CRC5_RES   = 5'h0C;

endpackage

// File: rtl/usbh_crc_step.sv
// One-bit serial CRC update: shift left, fold in the generator when the
// feedback bit (incoming wire bit xor register MSB) is set.
module usbh_crc_step
   import usbh_crc_pkg::*;
#(
   parameter int               CRC_W = 16,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_POLY)
) (
   input  logic [CRC_W-1:0] crc_i,
   input  logic             bit_i,
   output logic [CRC_W-1:0] crc_o
);

   logic fb;

   // Feedback and polynomial fold for a single wire bit
   always_comb begin
      fb    = bit_i ^ crc_i[CRC_W-1];
      crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
   end

endmodule

// File: rtl/usbh_crc_engine.sv
// Bit-serial USB CRC5/CRC16 engine with a beat-level valid/ready input.
// Optional residue comparator enabled by macro USBH_CRC_MATCH_EN; without
// it match_o is tied low and everything else behaves identically.
//
// Handshake: a beat transfers on a rising clock edge where valid_i and
// ready_o are both 1; ready_o is 1 only in IDLE and does not depend on
// valid_i. The beat then occupies SHIFT for exactly its bit count.
module usbh_crc_engine
   import usbh_crc_pkg::*;
#(
   parameter int               CRC_W    = 16,
   parameter logic [CRC_W-1:0] POLY     = CRC_W'(CRC16_POLY),
   parameter logic [CRC_W-1:0] INIT     = '1,
   parameter logic [CRC_W-1:0] RESIDUAL = CRC_W'(CRC16_RES)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [7:0]       data_i,
   input  logic [2:0]       nbits_i,
   input  logic             last_i,
   output logic [CRC_W-1:0] crc_o,
   output logic             done_o,
   output logic             match_o,
   output crc_state_e       state_o
);

   crc_state_e       state_q;
   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_next;
   logic [7:0]       data_q;
   logic [2:0]       cnt_q;
   logic [2:0]       last_idx_q;
   logic             last_q;
   logic             done_q;
   logic             match_q;
   logic             match_hit;

   usbh_crc_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_step (
      .crc_i (crc_q),
      .bit_i (data_q[cnt_q]),
      .crc_o (crc_next)
   );

`ifdef USBH_CRC_MATCH_EN
   // Residue check on the value the register takes with the final bit
   assign match_hit = (crc_next == RESIDUAL);
`else
   logic unused_residual;
   assign unused_residual = ^RESIDUAL;
   assign match_hit       = 1'b0;
`endif

   // Control FSM, bit counter, beat latch and CRC register; start_i overrides everything
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         crc_q      <= INIT;
         cnt_q      <= 3'd0;
         data_q     <= 8'd0;
         last_idx_q <= 3'd0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
         match_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         match_q <= 1'b0;
         if (start_i) begin
            crc_q   <= INIT;
            cnt_q   <= 3'd0;
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (valid_i) begin
                     data_q     <= data_i;
                     // nbits 0 means 8 bits; the 3-bit wrap of 0-1 gives index 7
                     last_idx_q <= nbits_i - 3'd1;
                     last_q     <= last_i;
                     cnt_q      <= 3'd0;
                     state_q    <= SHIFT;
                  end
               end
               SHIFT: begin
                  crc_q <= crc_next;
                  if (cnt_q == last_idx_q) begin
                     cnt_q <= 3'd0;
                     if (last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        match_q <= match_hit;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     cnt_q <= cnt_q + 3'd1;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign ready_o = (state_q == IDLE);
   assign crc_o   = ~crc_q;
   assign done_o  = done_q;
   assign match_o = match_q;
   assign state_o = state_q;

endmodule

// File: doc/usbh_crc_engine.md
USBH_CRC_ENGINE -- requirements
Module: usbh_crc_engine

Interface
REQ-001 The block SHALL have parameter CRC_W, default 16, meaning CRC width (legal values 5 or 16).
REQ-002 The block SHALL have parameter POLY, default 16'h8005, meaning the generator polynomial without its top term (CRC5: 5'h05).
REQ-003 The block SHALL have parameter INIT, default all ones, meaning the register value loaded on start.
REQ-004 The block SHALL have parameter RESIDUAL, default 16'h800D, meaning the good-packet register residue (CRC5: 5'h0C).
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start_i, input, 1 bit: load INIT and abort any beat in progress.
REQ-008 The block SHALL have port valid_i, input, 1 bit: data_i beat offered.
REQ-009 The block SHALL have port ready_o, output, 1 bit: beat accepted when valid_i and ready_o are both 1.
REQ-010 The block SHALL have port data_i, input, 8 bits: beat bits, with bit 0 on the wire first.
REQ-011 The block SHALL have port nbits_i, input, 3 bits: valid bits in this beat, where 0 means 8 and n means bits [n-1:0].
REQ-012 The block SHALL have port last_i, input, 1 bit: final beat of the packet.
REQ-013 The block SHALL have port crc_o, output, CRC_W bits: ~crc_q, where bit CRC_W-1 is the first bit transmitted.
REQ-014 The block SHALL have port done_o, output, 1 bit: one-cycle pulse after the last beat's final bit.
REQ-015 The block SHALL have port match_o, output, 1 bit: crc_q == RESIDUAL, qualified by done_o.

Function
REQ-016 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-017 In IDLE, ready_o SHALL be 1, and an accepted beat SHALL latch data_i, bit count and last_i, clear bit counter, and go to SHIFT.
REQ-018 In SHIFT, the block SHALL process one bit per cycle: fb = data_q[cnt] ^ crc_q[CRC_W-1]; crc_q = {crc_q[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-019 In SHIFT, ready_o SHALL be 0, and the beat SHALL take exactly its bit count in cycles (1..8).
REQ-020 At the end of a beat, the FSM SHALL go to DONE if the latched last is 1, else to IDLE.
REQ-021 DONE SHALL last one cycle, assert done_o with match_o valid, and return to IDLE; ready_o SHALL be 0 in DONE.
REQ-022 start_i SHALL take priority in every state: crc_q <= INIT, state <= IDLE, no done_o pulse, and any beat offered in the same cycle SHALL be ignored.
REQ-023 Without start_i, successive packets SHALL continue from the current crc_q; the register SHALL NOT auto-reinit.
REQ-024 crc_o SHALL be continuously valid in IDLE and DONE, and SHALL be undefined for checking while in SHIFT.
REQ-025 Throughput SHALL be one beat per (bit count + 1) cycles, plus 1 cycle for DONE on the last beat.

Reset
REQ-026 While rst_i is high, the block SHALL set state = IDLE, crc_q = INIT, counter = 0, ready_o = 1, done_o = 0, match_o = 0, and crc_o = ~INIT.
REQ-027 Reset asserted mid-beat SHALL discard the beat, and the first clock after deassertion SHALL behave as IDLE.

Configuration
REQ-028 The block SHALL use macro USBH_CRC_MATCH_EN to control residue checking.
REQ-029 With USBH_CRC_MATCH_EN defined, the block SHALL include the RESIDUAL comparator and drive match_o per REQ-015.
REQ-030 With USBH_CRC_MATCH_EN undefined, the block SHALL omit the comparator and tie match_o to 0, while all other behaviour is identical.

Structure
REQ-031 Package usbh_crc_pkg SHALL hold the state enum typedef and the constants CRC16_POLY = 16'h8005, CRC16_RES = 16'h800D, CRC5_POLY = 5'h05 and CRC5_RES = 5'h0C.
REQ-032 The one-bit update SHALL be a combinational sub-module usbh_crc_step (crc_i, bit_i -> crc_o) parametrised by CRC_W/POLY; the FSM and counters SHALL stay in usbh_crc_engine.

Verification
REQ-033 Scenario, CRC16 empty packet: start_i only -> crc_o = 16'h0000.
REQ-034 Scenario, CRC5 SETUP token: start_i; beat 8'h00, nbits 0; beat 3'b000, nbits 3, last -> done_o after 1+8+1+3+1 cycles and crc_o = 5'h02.
REQ-035 Scenario, CRC16 receive check: start_i; beats 8'h00, 8'h00, last on the second -> done_o with match_o = 1; the same with a corrupted second byte 8'h01 -> match_o = 0.
REQ-036 Scenario, backpressure: valid_i held high continuously -> ready_o is 0 for exactly the bit count of each beat, with no beat lost or duplicated against a reference model.
REQ-037 Scenario, abort: start_i at cycle 4 of an 8-bit SHIFT -> no done_o, crc_o = ~INIT next cycle, and a new packet computes correctly.
REQ-038 Scenario, async reset: rst_i pulsed mid-SHIFT between clock edges -> outputs reach reset values immediately, without a clock edge.
